// File: rtl/core_pkg.sv
// Shared types and defaults for the Selen core pipeline sequencer.
package core_pkg;

    typedef enum logic [1:0] {
        IRun,
        IWait,
        IDrop
    } i_state_e;

    typedef enum logic {
        DRun,
        DWait
    } d_state_e;

    localparam int unsigned CntWDef   = 32;
    localparam int unsigned TmoCycDef = 1024;

endpackage

// File: rtl/core_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module core_sat_cnt #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !(&cnt_q)) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/core_pipe_ctrl.sv
// Pipeline sequencer: per-stage enable/kill strobes from L1 handshakes, branch flush and
// load-use hazard, with fetch-discard tracking, stall/flush counters and a D-side timeout.
module core_pipe_ctrl
    import core_pkg::*;
#(
    parameter int unsigned CNT_W   = CntWDef,
    parameter int unsigned TMO_CYC = TmoCycDef
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic             if_ack,
    input  logic             mem_req,
    input  logic             mem_ack,
    input  logic             exe_valid,
    input  logic             exe_is_load,
    input  logic [4:0]       exe_rd,
    input  logic [4:0]       dec_rs1,
    input  logic [4:0]       dec_rs2,
    input  logic             dec_use_rs1,
    input  logic             dec_use_rs2,
    input  logic             exe2haz_brnch_tknn,
    output logic             if_enb,
    output logic             dec_enb,
    output logic             exe_enb,
    output logic             mem_enb,
    output logic             if_kill,
    output logic             dec_kill,
    output logic             exe_kill,
    output logic             mem_kill,
    output logic             pc_redirect,
    output logic             err_tmo,
    output logic [CNT_W-1:0] cnt_dstall,
    output logic [CNT_W-1:0] cnt_istall,
    output logic [CNT_W-1:0] cnt_flush
);

    localparam int unsigned TmoW = $clog2(TMO_CYC + 1);
    localparam logic [TmoW-1:0] TmoMax  = TmoW'(TMO_CYC);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TMO_CYC - 1);

    d_state_e d_q, d_d;
    i_state_e i_q, i_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic err_q, err_d;

    logic dst, flush, luse, istall;
    logic rs1_hit, rs2_hit;

    assign dst = (d_q == DRun && mem_req && !mem_ack) || (d_q == DWait && !mem_ack);

    // Exe inputs are held during a D-stall, so a suppressed flush re-evaluates afterwards.
    assign flush = exe_valid && exe2haz_brnch_tknn && !dst;

    assign rs1_hit = dec_use_rs1 && (dec_rs1 == exe_rd);
    assign rs2_hit = dec_use_rs2 && (dec_rs2 == exe_rd);
    assign luse    = exe_valid && exe_is_load && (exe_rd != 5'd0) && (rs1_hit || rs2_hit);

    assign istall = (if_req && !if_ack) || (i_q == IWait && !if_ack) || (i_q == IDrop);

    always_comb begin
        d_d = d_q;
        unique case (d_q)
            DRun:  if (mem_req && !mem_ack) d_d = DWait;
            DWait: if (mem_ack) d_d = DRun;
            default: d_d = DRun;
        endcase
    end

    // The I-FSM keeps tracking L1I even while the D-side stalls.
    always_comb begin
        i_d = i_q;
        unique case (i_q)
            IRun: begin
                if (if_req && !if_ack) i_d = flush ? IDrop : IWait;
            end
            IWait: begin
                if (if_ack) begin
                    i_d = IRun;
                end else if (flush) begin
                    i_d = IDrop;
                end
            end
            IDrop: begin
                if (if_ack) i_d = IRun;
            end
            default: i_d = IRun;
        endcase
    end

    always_comb begin
        tmo_d = '0;
        err_d = err_q;
        if (d_q == DWait) begin
            if (tmo_q == TmoLast) err_d = 1'b1;
            if (d_d == DWait && tmo_q != TmoMax) begin
                tmo_d = tmo_q + TmoW'(1);
            end else if (d_d == DWait) begin
                tmo_d = tmo_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q   <= DRun;
            i_q   <= IRun;
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            d_q   <= d_d;
            i_q   <= i_d;
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign err_tmo = err_q;

    always_comb begin
        if_enb      = 1'b1;
        dec_enb     = 1'b1;
        exe_enb     = 1'b1;
        mem_enb     = 1'b1;
        if_kill     = 1'b0;
        dec_kill    = 1'b0;
        exe_kill    = 1'b0;
        mem_kill    = 1'b0;
        pc_redirect = 1'b0;
        if (rst) begin
            if_enb   = 1'b0;
            dec_enb  = 1'b0;
            exe_enb  = 1'b0;
            mem_enb  = 1'b0;
            if_kill  = 1'b1;
            dec_kill = 1'b1;
            exe_kill = 1'b1;
            mem_kill = 1'b1;
        end else if (dst) begin
            if_enb   = 1'b0;
            dec_enb  = 1'b0;
            exe_enb  = 1'b0;
            mem_enb  = 1'b0;
            mem_kill = 1'b1;
        end else if (flush) begin
            pc_redirect = 1'b1;
            if_kill     = 1'b1;
            dec_kill    = 1'b1;
        end else if (luse) begin
            if_enb   = 1'b0;
            dec_enb  = 1'b0;
            dec_kill = 1'b1;
        end else if (istall) begin
            if_enb  = 1'b0;
            if_kill = 1'b1;
        end
    end

    core_sat_cnt #(
        .Width (CNT_W)
    ) u_cnt_dstall (
        .clk_i (clk),
        .rst_i (rst),
        .inc_i (dst),
        .clr_i (1'b0),
        .cnt_o (cnt_dstall)
    );

    core_sat_cnt #(
        .Width (CNT_W)
    ) u_cnt_istall (
        .clk_i (clk),
        .rst_i (rst),
        .inc_i (istall && !dst),
        .clr_i (1'b0),
        .cnt_o (cnt_istall)
    );

    core_sat_cnt #(
        .Width (CNT_W)
    ) u_cnt_flush (
        .clk_i (clk),
        .rst_i (rst),
        .inc_i (flush),
        .clr_i (1'b0),
        .cnt_o (cnt_flush)
    );

endmodule

// File: tb/tb_core_pipe_ctrl.sv
// Directed bench for core_pipe_ctrl with a cycle-level reference model and literal spot checks.
module tb_core_pipe_ctrl;

    localparam int unsigned CW  = 4;
    localparam int unsigned TMO = 8;
    localparam int          CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic if_req, if_ack, mem_req, mem_ack;
    logic exe_valid, exe_is_load, exe2haz_brnch_tknn;
    logic [4:0] exe_rd, dec_rs1, dec_rs2;
    logic dec_use_rs1, dec_use_rs2;
    logic if_enb, dec_enb, exe_enb, mem_enb;
    logic if_kill, dec_kill, exe_kill, mem_kill;
    logic pc_redirect, err_tmo;
    logic [CW-1:0] cnt_dstall, cnt_istall, cnt_flush;

    always #5 clk = ~clk;

    core_pipe_ctrl #(
        .CNT_W   (CW),
        .TMO_CYC (TMO)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .if_req             (if_req),
        .if_ack             (if_ack),
        .mem_req            (mem_req),
        .mem_ack            (mem_ack),
        .exe_valid          (exe_valid),
        .exe_is_load        (exe_is_load),
        .exe_rd             (exe_rd),
        .dec_rs1            (dec_rs1),
        .dec_rs2            (dec_rs2),
        .dec_use_rs1        (dec_use_rs1),
        .dec_use_rs2        (dec_use_rs2),
        .exe2haz_brnch_tknn (exe2haz_brnch_tknn),
        .if_enb             (if_enb),
        .dec_enb            (dec_enb),
        .exe_enb            (exe_enb),
        .mem_enb            (mem_enb),
        .if_kill            (if_kill),
        .dec_kill           (dec_kill),
        .exe_kill           (exe_kill),
        .mem_kill           (mem_kill),
        .pc_redirect        (pc_redirect),
        .err_tmo            (err_tmo),
        .cnt_dstall         (cnt_dstall),
        .cnt_istall         (cnt_istall),
        .cnt_flush          (cnt_flush)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_cnt(input string name, input logic [CW-1:0] act, input int exp);
        n_checks++;
        if (act !== CW'(exp)) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_vec(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: "waiting on L1D", "fetch response owed", "response to be thrown away".
    bit m_dwait, m_pend, m_drop, m_err;
    int m_wc, m_cd, m_ci, m_cf;

    function automatic int sat_inc(input int x);
        return (x >= CMAX) ? CMAX : x + 1;
    endfunction

    // Strobe vector order: if/dec/exe/mem enb, if/dec/exe/mem kill, redirect.
    always @(negedge clk) begin
        logic [8:0] act, exp, msk;
        bit dst, flush, luse, istall;
        int n;
        act = {if_enb, dec_enb, exe_enb, mem_enb, if_kill, dec_kill, exe_kill, mem_kill,
               pc_redirect};
        if (rst) begin
            check_vec("model_rst_strobes", act, 9'b0000_1111_0);
            m_dwait = 0; m_pend = 0; m_drop = 0; m_err = 0;
            m_wc = 0; m_cd = 0; m_ci = 0; m_cf = 0;
        end else begin
            check_cnt("model_cnt_dstall", cnt_dstall, m_cd);
            check_cnt("model_cnt_istall", cnt_istall, m_ci);
            check_cnt("model_cnt_flush", cnt_flush, m_cf);
            check_bit("model_err_tmo", err_tmo, m_err);

            dst    = !mem_ack && (m_dwait || mem_req);
            flush  = exe_valid && exe2haz_brnch_tknn && !dst;
            luse   = exe_valid && exe_is_load && exe_rd != 0 &&
                     ((dec_use_rs1 && dec_rs1 == exe_rd) || (dec_use_rs2 && dec_rs2 == exe_rd));
            istall = (if_req && !if_ack) || (m_pend && !if_ack) || m_drop;

            msk = '1;
            if (dst)         exp = 9'b0000_0001_0;
            else if (flush) begin
                exp = 9'b0011_1100_1;
                msk = 9'b0011_1111_1;
            end
            else if (luse)   exp = 9'b0011_0100_0;
            else if (istall) exp = 9'b0111_1000_0;
            else             exp = 9'b1111_0000_0;
            check_vec("model_strobes", act & msk, exp & msk);

            if (m_dwait) begin
                n = m_wc + 1;
                if (n >= TMO) m_err = 1;
                m_wc = dst ? n : 0;
            end else begin
                m_wc = 0;
            end
            m_dwait = dst;

            if (m_drop) begin
                if (if_ack) m_drop = 0;
            end else if (m_pend) begin
                if (if_ack) m_pend = 0;
                else if (flush) begin
                    m_pend = 0;
                    m_drop = 1;
                end
            end else if (if_req && !if_ack) begin
                if (flush) m_drop = 1;
                else m_pend = 1;
            end

            if (dst) m_cd = sat_inc(m_cd);
            if (istall && !dst) m_ci = sat_inc(m_ci);
            if (flush) m_cf = sat_inc(m_cf);
        end
    end

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
        #1;
    endtask

    task automatic idle_in;
        if_req = 0; if_ack = 0; mem_req = 0; mem_ack = 0;
        exe_valid = 0; exe_is_load = 0; exe2haz_brnch_tknn = 0;
        exe_rd = 0; dec_rs1 = 0; dec_rs2 = 0; dec_use_rs1 = 0; dec_use_rs2 = 0;
    endtask

    task automatic do_reset;
        rst = 1;
        idle_in();
        nxt();
        nxt();
        rst = 0;
    endtask

    initial begin
        idle_in();
        rst = 1;
        nxt();
        sample();
        check_bit("rst_if_enb", if_enb, 1'b0);
        check_bit("rst_mem_kill", mem_kill, 1'b1);
        check_bit("rst_redirect", pc_redirect, 1'b0);
        nxt();
        rst = 0;
        sample();
        check_cnt("rst_cnt_dstall", cnt_dstall, 0);
        check_bit("rst_err_tmo", err_tmo, 1'b0);
        check_bit("idle_if_enb", if_enb, 1'b1);

        // Load-use hazard
        do_reset();
        exe_valid = 1; exe_is_load = 1; exe_rd = 5; dec_rs1 = 5; dec_use_rs1 = 1;
        sample();
        check_bit("luse_if_enb", if_enb, 1'b0);
        check_bit("luse_dec_kill", dec_kill, 1'b1);
        check_bit("luse_exe_enb", exe_enb, 1'b1);
        nxt();
        exe_valid = 0;
        sample();
        check_vec("luse_after_enb", {if_enb, dec_enb, exe_enb, mem_enb, dec_kill, 4'b0},
                  9'b1111_0_0000);
        nxt();
        exe_valid = 1; exe_rd = 0; dec_rs1 = 0;
        sample();
        check_bit("luse_rd0_dec_kill", dec_kill, 1'b0);
        nxt();
        exe_rd = 7; dec_rs1 = 3; dec_rs2 = 7; dec_use_rs1 = 1; dec_use_rs2 = 1;
        nxt();
        dec_use_rs2 = 0;
        nxt();
        idle_in();

        // L1D miss, then ack with request
        do_reset();
        mem_req = 1;
        repeat (3) begin
            sample();
            check_bit("dmiss_exe_enb", exe_enb, 1'b0);
            check_bit("dmiss_mem_kill", mem_kill, 1'b1);
            nxt();
        end
        mem_ack = 1;
        sample();
        check_bit("dack_mem_kill", mem_kill, 1'b0);
        check_bit("dack_exe_enb", exe_enb, 1'b1);
        check_cnt("dack_cnt_dstall", cnt_dstall, 3);
        nxt();
        mem_req = 1; mem_ack = 1;
        sample();
        check_bit("dhit_mem_kill", mem_kill, 1'b0);
        nxt();
        idle_in();
        sample();
        check_cnt("dhit_cnt_dstall", cnt_dstall, 3);

        // Branch during fetch miss
        do_reset();
        if_req = 1;
        sample();
        check_bit("imiss_if_kill", if_kill, 1'b1);
        nxt();
        if_req = 0; exe_valid = 1; exe2haz_brnch_tknn = 1;
        sample();
        check_bit("imiss_redirect", pc_redirect, 1'b1);
        nxt();
        exe_valid = 0; exe2haz_brnch_tknn = 0;
        repeat (2) begin
            sample();
            check_bit("idrop_if_kill", if_kill, 1'b1);
            nxt();
        end
        if_ack = 1;
        sample();
        check_bit("idrop_ack_if_kill", if_kill, 1'b1);
        nxt();
        if_ack = 0;
        sample();
        check_bit("idrop_done_if_kill", if_kill, 1'b0);
        check_cnt("idrop_cnt_flush", cnt_flush, 1);
        check_cnt("idrop_cnt_istall", cnt_istall, 5);

        // Branch taken while D-stalled
        do_reset();
        mem_req = 1; exe_valid = 1; exe2haz_brnch_tknn = 1;
        repeat (2) begin
            sample();
            check_bit("dst_br_redirect", pc_redirect, 1'b0);
            check_bit("dst_br_exe_enb", exe_enb, 1'b0);
            nxt();
        end
        mem_ack = 1;
        sample();
        check_bit("dst_br_ack_redirect", pc_redirect, 1'b1);
        check_cnt("dst_br_cnt_flush0", cnt_flush, 0);
        nxt();
        idle_in();
        sample();
        check_cnt("dst_br_cnt_flush1", cnt_flush, 1);

        // D-side timeout
        do_reset();
        mem_req = 1;
        for (int k = 0; k < 10; k++) begin
            sample();
            if (k == 8) check_bit("tmo_before", err_tmo, 1'b0);
            if (k == 9) check_bit("tmo_set", err_tmo, 1'b1);
            nxt();
        end
        mem_ack = 1;
        sample();
        check_bit("tmo_ack_sticky", err_tmo, 1'b1);
        nxt();
        idle_in();
        sample();
        check_bit("tmo_idle_sticky", err_tmo, 1'b1);
        check_cnt("tmo_cnt_dstall", cnt_dstall, 10);
        nxt();
        rst = 1;
        nxt();
        rst = 0;
        sample();
        check_bit("tmo_cleared", err_tmo, 1'b0);

        // I-side stall counter saturation
        do_reset();
        if_req = 1;
        repeat (20) nxt();
        sample();
        check_cnt("sat_cnt_istall", cnt_istall, 15);
        check_cnt("sat_cnt_dstall", cnt_dstall, 0);
        nxt();
        if_ack = 1;
        nxt();
        idle_in();
        nxt();
        sample();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
